// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional signed mode is selected by MUL_SIGNED_EN in the top module.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

    // Bits needed to count 0..value-1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_seq_32_if.sv
// Request/response bundle between the ALU (master) and the multiplier (slave).
interface mul_seq_32_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output done,
        output product
    );

endinterface

// File: rtl/fulladder_32bit.sv
// 32-bit ripple-carry adder built from per-bit full-adder cells.
module fulladder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[32];

endmodule

// File: rtl/mul_seq_32.sv
// Iterative shift-add multiplier: one partial-product add per clock, WIDTH iterations.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module mul_seq_32
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_seq_32_if.slave bus
);

    localparam int CW = clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    mul_state_t        state_q;
    logic              ready_q;
    logic              done_q;
    logic [PW-1:0]     product_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  m_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  q_q;

    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  q_d;
    logic [PW-1:0]     prod_mag;
    logic [PW-1:0]     product_d;
    logic [WIDTH-1:0]  m_load;
    logic [WIDTH-1:0]  q_load;

`ifdef MUL_SIGNED_EN
    logic              neg_q;
    logic              neg_load;

    // |INT_MIN| wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude
    assign m_load    = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign q_load    = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    assign neg_load  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    assign product_d = neg_q ? (~prod_mag + PW'(1)) : prod_mag;
`else
    assign m_load    = bus.a;
    assign q_load    = bus.b;
    assign product_d = prod_mag;
`endif

    // Single shared adder; the adder is fixed at 32 bits so WIDTH must stay 32
    assign add_b = q_q[0] ? m_q : '0;

    fulladder_32bit u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {C,A,Q} <= {cout,sum,Q} >> 1 : the carry lands in A's MSB, so C itself is always 0
    assign acc_d    = {add_cout, add_sum[WIDTH-1:1]};
    assign q_d      = {add_sum[0], q_q[WIDTH-1:1]};
    assign prod_mag = {acc_d, q_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
            count_q   <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
`ifdef MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= m_load;
                        q_q     <= q_load;
                        acc_q   <= '0;
                        count_q <= '0;
                        ready_q <= 1'b0;
`ifdef MUL_SIGNED_EN
                        neg_q   <= neg_load;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    // Result is registered on the last add so it is valid alongside done
                    if (count_q == CW'(WIDTH - 1)) begin
                        product_q <= product_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
